// File: rtl/rot_loader_pkg.sv
// Shared definitions for the rotating-register loader.
// Holds the slot count, phase counter width, load lead, the loader
// state encoding and a nibble select helper used by the strobe mux.
package rot_loader_pkg;

    localparam int NIBBLES = 8;
    localparam int PHASE_W = $clog2(NIBBLES);
    // The rotating register shows a loaded nibble one cycle after set_data.
    localparam int LEAD    = 1;

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        LOAD
    } load_state_t;

    // Returns nibble idx of a packed word (nibble k = word[4k+3:4k]).
    function automatic logic [3:0] nib_sel(input logic [4*NIBBLES-1:0] word,
                                           input logic [PHASE_W-1:0]   idx);
        logic [4*NIBBLES-1:0] shifted;
        shifted = word >> {idx, 2'b00};
        return shifted[3:0];
    endfunction

endpackage

// File: rtl/rot_phase_counter.sv
// Free-running phase counter shared by the loader and the rotating
// register, so both always agree on which nibble slot is current.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset, clears the count
//   count  - current phase, increments every clock and wraps naturally
module rot_phase_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/rot_loader.sv
// Upstream feeder for the 32-bit nibble-rotating register.
// Accepts a word plus byte strobe, waits for the phase counter to reach
// the last slot, then spends one full rotation driving set_data/data_in
// so that each enabled nibble lands in the slot that is displayed when
// the counter equals its index.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   wr_valid/wr_ready  - write handshake (accepted when both high)
//   wr_data, wr_strb   - word and byte enables (bit b covers nibbles 2b, 2b+1)
//   counter            - shared free-running phase
//   rot_data, rot_set  - registered drive to the rotating register
//   busy               - a write is waiting for alignment or being loaded
module rot_loader
    import rot_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [31:0]        wr_data,
    input  logic [3:0]         wr_strb,
    output logic [PHASE_W-1:0] counter,
    output logic [3:0]         rot_data,
    output logic               rot_set,
    output logic               busy
);

    load_state_t        state;
    load_state_t        state_next;
    logic [31:0]        shadow_data;
    logic [3:0]         shadow_strb;
    logic               capture;
    logic               phase_end;
    logic [PHASE_W-1:0] next_idx;
    logic               set_next;
    logic [3:0]         data_next;

    rot_phase_counter #(
        .WIDTH (PHASE_W)
    ) u_phase (
        .clk   (clk),
        .rst_n (rst_n),
        .count (counter)
    );

    assign phase_end = (counter == PHASE_W'(NIBBLES - 1));

    // An all-zero strobe is acknowledged but carries nothing to load.
    assign capture = wr_valid && wr_ready && (wr_strb != 4'b0000);

    // Outputs are registered, so the value computed now is seen in the
    // cycle with counter+1, which must target nibble (counter+1)+LEAD.
    assign next_idx = counter + PHASE_W'(1 + LEAD);

    assign busy = (state != IDLE);

    // Next-state logic: IDLE waits for a write, ALIGN waits for the
    // last phase slot, LOAD covers exactly one full rotation.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_next = ALIGN;
                end
            end
            ALIGN: begin
                if (phase_end) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (phase_end) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Strobe mux: a masked nibble leaves set low so the register keeps
    // recirculating its old content; data is forced to zero with it.
    always_comb begin
        set_next  = 1'b0;
        data_next = 4'h0;
        if (state_next == LOAD) begin
            set_next = shadow_strb[next_idx[PHASE_W-1:1]];
            if (set_next) begin
                data_next = nib_sel(shadow_data, next_idx);
            end
        end
    end

    // State, handshake and output registers. wr_ready is registered so it
    // stays low for as long as reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_ready    <= 1'b0;
            rot_set     <= 1'b0;
            rot_data    <= 4'h0;
            shadow_data <= '0;
            shadow_strb <= '0;
        end else begin
            state    <= state_next;
            wr_ready <= (state_next == IDLE);
            rot_set  <= set_next;
            rot_data <= data_next;
            if (capture) begin
                shadow_data <= wr_data;
                shadow_strb <= wr_strb;
            end
        end
    end

endmodule

// File: tb/tb_rot_loader.sv
// Self-checking bench for rot_loader. A schedule-based model predicts the
// outputs every cycle; a model of the external rotating register, fed by
// the DUT's drive, gives the displayed word for hand-computed checks.
module tb_rot_loader;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [2:0]  counter;
    logic [3:0]  rot_data;
    logic        rot_set;
    logic        busy;

    rot_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .wr_strb  (wr_strb),
        .counter  (counter),
        .rot_data (rot_data),
        .rot_set  (rot_set),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } lit_t;
    lit_t lit_q[$];

    // Model state
    int          t_now      = 0;
    int          load_start = 0;
    int          load_end   = 0;
    int          m_cnt      = 0;
    bit          m_ready    = 0;
    bit          m_active   = 0;
    bit          m_in_load  = 0;
    bit          m_set      = 0;
    logic [3:0]  m_data     = 4'h0;
    logic [31:0] m_word     = '0;
    logic [3:0]  m_strb     = '0;
    int          n_acc      = 0;
    int          n_set      = 0;
    int          n_busy     = 0;
    int          set_hits[8] = '{default: 0};
    logic [3:0]  disp[8];

    int snap[8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pushLit(input string name, input logic [31:0] act, input logic [31:0] exp);
        lit_t e;
        e.name = name;
        e.act  = act;
        e.exp  = exp;
        lit_q.push_back(e);
    endtask

    function automatic logic [31:0] dispWord();
        logic [31:0] w;
        w = '0;
        for (int c = 0; c < 8; c++) begin
            w[4*c +: 4] = disp[c];
        end
        return w;
    endfunction

    task automatic takeSnap();
        for (int c = 0; c < 8; c++) snap[c] = set_hits[c];
    endtask

    function automatic logic [7:0] hitMask();
        logic [7:0] m;
        m = '0;
        for (int c = 0; c < 8; c++) m[c] = (set_hits[c] != snap[c]);
        return m;
    endfunction

    // Behavioural model: each accepted write schedules a loading window that
    // starts at the next phase-0 cycle after at least one waiting cycle and
    // lasts one rotation; ready is simply the absence of such a window.
    initial forever begin
        int j;
        bit hs;
        @(posedge clk);
        if (!rst_n) begin
            m_cnt = 0; m_ready = 0; m_active = 0; m_in_load = 0;
            m_set = 0; m_data = 4'h0; t_now = 0;
        end else begin
            if (rot_set) begin
                disp[(int'(counter) + 1) % 8] = rot_data;
                n_set++;
                set_hits[counter]++;
            end
            if (busy) n_busy++;
            hs = wr_valid && m_ready;
            t_now++;
            m_cnt = (m_cnt + 1) % 8;
            if (hs) begin
                n_acc++;
                if (wr_strb != 4'b0000) begin
                    m_active   = 1;
                    m_word     = wr_data;
                    m_strb     = wr_strb;
                    load_start = t_now + (8 - m_cnt);
                    load_end   = load_start + 7;
                end
            end
            if (m_active && t_now > load_end) m_active = 0;
            m_ready   = !m_active;
            m_in_load = m_active && (t_now >= load_start);
            if (m_in_load) begin
                j      = (m_cnt + 1) % 8;
                m_set  = m_strb[j / 2];
                m_data = m_set ? 4'((m_word >> (4 * j)) & 32'hF) : 4'h0;
            end else begin
                m_set  = 0;
                m_data = 4'h0;
            end
        end
    end

    // Compare process: every cycle, shortly after the clock edge.
    initial forever begin
        lit_t e;
        @(posedge clk);
        #2;
        if (!rst_n) begin
            checkOutput("rst_counter", 32'(counter), 32'd0);
            checkOutput("rst_ready", 32'(wr_ready), 32'd0);
            checkOutput("rst_busy", 32'(busy), 32'd0);
            checkOutput("rst_set", 32'(rot_set), 32'd0);
            checkOutput("rst_data", 32'(rot_data), 32'd0);
        end else begin
            checkOutput("counter", 32'(counter), 32'(m_cnt));
            checkOutput("wr_ready", 32'(wr_ready), 32'(m_ready));
            checkOutput("busy", 32'(busy), 32'(m_active));
            checkOutput("rot_set", 32'(rot_set), 32'(m_set));
            checkOutput("rot_data", 32'(rot_data), 32'(m_data));
        end
        while (lit_q.size() > 0) begin
            e = lit_q.pop_front();
            checkOutput(e.name, e.act, e.exp);
        end
    end

    // Drives one write; at_cnt < 0 means any phase.
    task automatic applyStimulus(input logic [31:0] d, input logic [3:0] s, input int at_cnt);
        bit ok;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (m_ready && (at_cnt < 0 || m_cnt == at_cnt)) ok = 1;
        end
        if (!ok) pushLit("stim_timeout", 32'd0, 32'd1);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_strb  = s;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic waitIdle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (!m_active) ok = 1;
        end
        if (!ok) pushLit("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int base_set;
        int base_busy;
        int base_acc;
        bit ok;

        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_strb  = '0;
        repeat (3) @(negedge clk);
        pushLit("reset_ready", 32'(wr_ready), 32'd0);
        pushLit("reset_counter", 32'(counter), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] full write at phase 3");
        base_set = n_set; base_busy = n_busy; takeSnap();
        applyStimulus(32'h7654_3210, 4'hF, 3);
        pushLit("t1_ready_drop", 32'(wr_ready), 32'd0);
        pushLit("t1_busy", 32'(busy), 32'd1);
        waitIdle();
        pushLit("t1_set_count", 32'(n_set - base_set), 32'd8);
        pushLit("t1_set_mask", 32'(hitMask()), 32'hFF);
        pushLit("t1_busy_cycles", 32'(n_busy - base_busy), 32'd12);
        pushLit("t1_display", dispWord(), 32'h7654_3210);

        $display("[TB] partial write, byte 2 only");
        base_set = n_set; takeSnap();
        applyStimulus(32'hAAAA_BBBB, 4'b0100, -1);
        waitIdle();
        pushLit("t2_set_count", 32'(n_set - base_set), 32'd2);
        pushLit("t2_set_mask", 32'(hitMask()), 32'h18);
        pushLit("t2_display", dispWord(), 32'h76AA_3210);

        $display("[TB] write accepted at phase 7");
        base_set = n_set; base_busy = n_busy;
        applyStimulus(32'h0123_4567, 4'hF, 7);
        waitIdle();
        pushLit("t3_busy_cycles", 32'(n_busy - base_busy), 32'd16);
        pushLit("t3_set_count", 32'(n_set - base_set), 32'd8);
        pushLit("t3_display", dispWord(), 32'h0123_4567);

        $display("[TB] second write stalled during load");
        base_acc = n_acc;
        applyStimulus(32'h1357_9BDF, 4'hF, -1);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (m_in_load) ok = 1;
        end
        if (!ok) pushLit("t4_load_timeout", 32'd0, 32'd1);
        wr_valid = 1'b1;
        wr_data  = 32'hFFFF_FFFF;
        wr_strb  = 4'hF;
        pushLit("t4_stall_ready", 32'(wr_ready), 32'd0);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (m_ready) ok = 1;
        end
        if (!ok) pushLit("t4_accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        wr_valid = 1'b0;
        waitIdle();
        pushLit("t4_accepts", 32'(n_acc - base_acc), 32'd2);
        pushLit("t4_display", dispWord(), 32'hFFFF_FFFF);

        $display("[TB] reset during load");
        applyStimulus(32'h2468_ACE0, 4'hF, -1);
        base_set = n_set;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (n_set - base_set >= 3) ok = 1;
        end
        if (!ok) pushLit("t5_load_timeout", 32'd0, 32'd1);
        pushLit("t5_set_before", 32'(rot_set), 32'd1);
        rst_n = 1'b0;
        #1;
        pushLit("t5_counter", 32'(counter), 32'd0);
        pushLit("t5_busy", 32'(busy), 32'd0);
        pushLit("t5_set", 32'(rot_set), 32'd0);
        pushLit("t5_data", 32'(rot_data), 32'd0);
        pushLit("t5_ready", 32'(wr_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base_set = n_set;
        repeat (12) @(negedge clk);
        pushLit("t5_no_set", 32'(n_set - base_set), 32'd0);
        pushLit("t5_idle_busy", 32'(busy), 32'd0);

        $display("[TB] zero strobe write");
        applyStimulus(32'hCAFE_F00D, 4'hF, -1);
        waitIdle();
        pushLit("t6_display_before", dispWord(), 32'hCAFE_F00D);
        base_set = n_set; base_acc = n_acc;
        applyStimulus(32'h0000_0000, 4'h0, -1);
        pushLit("t6_ready", 32'(wr_ready), 32'd1);
        pushLit("t6_busy", 32'(busy), 32'd0);
        repeat (12) @(negedge clk);
        pushLit("t6_accepts", 32'(n_acc - base_acc), 32'd1);
        pushLit("t6_no_set", 32'(n_set - base_set), 32'd0);
        pushLit("t6_display", dispWord(), 32'hCAFE_F00D);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
